// File: rtl/run_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : run_sequencer_if
//  Description : Run-control bundle between the testbench / decoder and the
//                run sequencer: Start/Halt in, PC control and run status out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface run_sequencer_if #(
    parameter int IDX_W = 2,
    parameter int CNT_W = 16
) ();

    logic             Start;
    logic             Halt;
    logic             CountEn;
    logic             PcLoad;
    logic [IDX_W-1:0] ProgIdx;
    logic             Done;
    logic             Timeout;
    logic [CNT_W-1:0] CycleCount;

    // Sequencer side: consumes Start/Halt, drives PC control and status.
    modport master (
        input  Start,
        input  Halt,
        output CountEn,
        output PcLoad,
        output ProgIdx,
        output Done,
        output Timeout,
        output CycleCount
    );

    // Environment side: testbench/decoder drive Start/Halt, observe status.
    modport slave (
        output Start,
        output Halt,
        input  CountEn,
        input  PcLoad,
        input  ProgIdx,
        input  Done,
        input  Timeout,
        input  CycleCount
    );

endinterface
`default_nettype wire

// File: rtl/run_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : run_sequencer
//  Description : Run controller for the 3BC processor. Arms a program on a
//                Start rise (PC held at the entry address), runs it once Start
//                falls, and stops on Halt or on the watchdog limit, reporting
//                Done, Timeout and the number of RUN cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module run_sequencer #(
    parameter int PROG_COUNT = 3,
    parameter int IDX_W      = 2,
    parameter int CNT_W      = 16,
    parameter int MAX_CYCLES = 50000
) (
    input  logic            Clk,
    input  logic            Reset_n,
    run_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Last valid program index; the index wraps to 0 after it.
    localparam logic [IDX_W-1:0] c_last_idx  = IDX_W'(PROG_COUNT - 1);
    // Count value seen during the final permitted RUN cycle.
    localparam logic [CNT_W-1:0] c_wdog_last = CNT_W'(MAX_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_prog_idx;
    logic [IDX_W-1:0] w_prog_idx_nxt;
    logic             r_timeout;
    logic             w_timeout_nxt;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] w_cycle_cnt_nxt;

    // State and run-status registers; reset returns to IDLE with program 0.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= ST_IDLE;
            r_prog_idx  <= '0;
            r_timeout   <= 1'b0;
            r_cycle_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_prog_idx  <= w_prog_idx_nxt;
            r_timeout   <= w_timeout_nxt;
            r_cycle_cnt <= w_cycle_cnt_nxt;
        end
    end

    // Next-state and status update; Start beats Halt, Halt beats the watchdog.
    always_comb begin
        w_state_nxt     = r_state;
        w_prog_idx_nxt  = r_prog_idx;
        w_timeout_nxt   = r_timeout;
        w_cycle_cnt_nxt = r_cycle_cnt;

        case (r_state)
            ST_IDLE: begin
                // A Start already high when reset releases is taken as a rise.
                if (bus.Start) begin
                    w_state_nxt     = ST_ARMED;
                    w_cycle_cnt_nxt = '0;
                    w_timeout_nxt   = 1'b0;
                end
            end

            ST_ARMED: begin
                // Start held high keeps the PC parked on the entry address.
                if (!bus.Start) begin
                    w_state_nxt = ST_RUN;
                end
            end

            ST_RUN: begin
                if (bus.Start) begin
                    // Abort and re-arm the same program.
                    w_state_nxt     = ST_ARMED;
                    w_cycle_cnt_nxt = '0;
                    w_timeout_nxt   = 1'b0;
                end else begin
                    // Every RUN cycle is counted, including the stopping one.
                    w_cycle_cnt_nxt = r_cycle_cnt + CNT_W'(1);
                    if (bus.Halt) begin
                        w_state_nxt = ST_DONE;
                    end else if (r_cycle_cnt == c_wdog_last) begin
                        w_state_nxt   = ST_DONE;
                        w_timeout_nxt = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                // Halt is ignored here; only a new Start moves on.
                if (bus.Start) begin
                    w_state_nxt     = ST_ARMED;
                    w_cycle_cnt_nxt = '0;
                    w_timeout_nxt   = 1'b0;
                    w_prog_idx_nxt  = (r_prog_idx == c_last_idx) ? '0
                                                                 : r_prog_idx + IDX_W'(1);
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Moore outputs decoded straight from the state and status registers.
    assign bus.CountEn    = (r_state == ST_RUN);
    assign bus.PcLoad     = (r_state == ST_ARMED);
    assign bus.Done       = (r_state == ST_DONE);
    assign bus.ProgIdx    = r_prog_idx;
    assign bus.Timeout    = r_timeout;
    assign bus.CycleCount = r_cycle_cnt;

endmodule
`default_nettype wire

// File: tb/tb_run_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_run_sequencer
//  Description : Self-checking bench for run_sequencer. Expected run length,
//                timeout flag and program index come from a run-level model
//                (halt length vs. watchdog limit, completed-run counter).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_run_sequencer;

    localparam int PROG_COUNT = 3;
    localparam int IDX_W      = 2;
    localparam int CNT_W      = 16;
    localparam int MAX_CYCLES = 20;

    logic Clk = 1'b0;
    logic Reset_n;

    int checks = 0;
    int errors = 0;

    // Run-level model state.
    int exp_idx   = 0;
    bit finished  = 1'b0;
    int last_runs = 0;
    int last_to   = 0;

    run_sequencer_if #(.IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

    run_sequencer #(
        .PROG_COUNT (PROG_COUNT),
        .IDX_W      (IDX_W),
        .CNT_W      (CNT_W),
        .MAX_CYCLES (MAX_CYCLES)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int ce, input int pl, input int idx,
                           input int dn, input int to, input int cc);
        chk({tag, ".CountEn"},    32'(bus.CountEn),    ce);
        chk({tag, ".PcLoad"},     32'(bus.PcLoad),     pl);
        chk({tag, ".ProgIdx"},    32'(bus.ProgIdx),    idx);
        chk({tag, ".Done"},       32'(bus.Done),       dn);
        chk({tag, ".Timeout"},    32'(bus.Timeout),    to);
        chk({tag, ".CycleCount"}, 32'(bus.CycleCount), cc);
    endtask

    // Raise Start for n cycles; a new program is selected only after a finished run.
    task automatic arm(input int n);
        if (finished) exp_idx = (exp_idx + 1) % PROG_COUNT;
        finished  = 1'b0;
        bus.Start = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            chk_all("armed", 0, 1, exp_idx, 0, 0, 0);
        end
        bus.Start = 1'b0;
    endtask

    // Let the program run; Halt is raised during RUN cycle number len if halt_it.
    task automatic run_body(input int len, input bit halt_it);
        int runcnt = 0;
        bit ended  = 1'b0;
        bit halted = halt_it && (len <= MAX_CYCLES);
        int exp_runs = halted ? len : MAX_CYCLES;
        int exp_to   = halted ? 0 : 1;
        for (int i = 0; i < MAX_CYCLES + 5 && !ended; i++) begin
            @(negedge Clk);
            if (bus.CountEn !== 1'b1) begin
                ended = 1'b1;
            end else begin
                runcnt++;
                chk("run.CycleCount", 32'(bus.CycleCount), runcnt - 1);
                chk("run.PcLoad", 32'(bus.PcLoad), 0);
                bus.Halt = halt_it && (runcnt == len);
            end
        end
        bus.Halt = 1'b0;
        chk("run_bound", 32'(ended), 1);
        chk("run_len", runcnt, exp_runs);
        chk_all("done", 0, 0, exp_idx, 1, exp_to, exp_runs);
        finished  = 1'b1;
        last_runs = exp_runs;
        last_to   = exp_to;
    endtask

    task automatic run_program(input int n_start, input int len, input bit halt_it);
        arm(n_start);
        run_body(len, halt_it);
    endtask

    // Hard stop in case the bench itself loses its way.
    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int k;
        Reset_n   = 1'b0;
        bus.Start = 1'b0;
        bus.Halt  = 1'b0;

        // Reset held for three cycles.
        repeat (3) begin
            @(negedge Clk);
            chk_all("reset", 0, 0, 0, 0, 0, 0);
        end
        Reset_n = 1'b1;

        // Halt toggling in IDLE must not move the block.
        for (int i = 0; i < 50; i++) begin
            bus.Halt = 1'($urandom_range(0, 1));
            @(negedge Clk);
            chk_all("idle_quiet", 0, 0, 0, 0, 0, 0);
        end
        bus.Halt = 1'b0;

        // First program: two-cycle Start pulse, halt after 10 RUN cycles.
        run_program(2, 10, 1'b1);

        // Three more halted programs: index walks 1, 2, 0.
        for (int i = 0; i < 3; i++) begin
            run_program(int'($urandom_range(1, 3)), int'($urandom_range(1, 15)), 1'b1);
        end

        // Halt toggling in DONE must leave the result frozen.
        for (int i = 0; i < 50; i++) begin
            bus.Halt = 1'($urandom_range(0, 1));
            @(negedge Clk);
            chk_all("done_quiet", 0, 0, exp_idx, 1, last_to, last_runs);
        end
        bus.Halt = 1'b0;

        // Watchdog: no Halt at all.
        run_program(1, 1000, 1'b0);
        // Halt on the very last permitted cycle wins over the watchdog.
        run_program(1, MAX_CYCLES, 1'b1);
        // Halt one cycle before the limit.
        run_program(1, MAX_CYCLES - 1, 1'b1);

        // Start and Halt together in RUN: re-arm the same program.
        arm(1);
        k = int'($urandom_range(2, 8));
        for (int i = 1; i <= k; i++) begin
            @(negedge Clk);
            chk("abort_run.CycleCount", 32'(bus.CycleCount), i - 1);
        end
        bus.Start = 1'b1;
        bus.Halt  = 1'b1;
        @(negedge Clk);
        chk_all("abort", 0, 1, exp_idx, 0, 0, 0);
        bus.Halt = 1'b0;
        arm(1);
        run_body(int'($urandom_range(1, 12)), 1'b1);

        // Randomised runs: halt point may fall before, on or past the limit.
        for (int i = 0; i < 6; i++) begin
            run_program(int'($urandom_range(1, 3)), int'($urandom_range(1, MAX_CYCLES + 5)),
                        ($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset while running.
        arm(1);
        repeat (3) @(negedge Clk);
        chk("mid_run.CountEn", 32'(bus.CountEn), 1);
        #1 Reset_n = 1'b0;
        #1 chk_all("async_rst", 0, 0, 0, 0, 0, 0);
        @(negedge Clk);
        Reset_n  = 1'b1;
        exp_idx  = 0;
        finished = 1'b0;
        @(negedge Clk);
        chk_all("post_rst_idle", 0, 0, 0, 0, 0, 0);
        run_program(1, 6, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
Top-level run controller for the 3BC processor. Sequences the execution of consecutive programs:
- arms on a Start pulse from the testbench and holds the PC at the selected program's entry;
- enables PC counting once Start falls;
- stops on the decoder's Halt or on a watchdog timeout, then reports Done and the cycle count.

It sits between the testbench and the program counter / instruction ROM address logic.

Parameters:
PROG_COUNT, 3, number of programs in instruction memory; ProgIdx wraps modulo this value (must be ≥1).
IDX_W, 2, width of ProgIdx (must satisfy 2^IDX_W ≥ PROG_COUNT).
CNT_W, 16, width of CycleCount.
MAX_CYCLES, 50000, watchdog limit in RUN cycles (1 ≤ MAX_CYCLES ≤ 2^CNT_W−1).

Ports:
Clk  input  1  system clock; all state changes on its rising edge.
Reset_n  input  1  asynchronous, active-low reset.
Start  input  1  level from testbench; rise arms or restarts, fall launches the run.
Halt  input  1  from decoder; high while a halt instruction is at the PC.
CountEn  output  1  PC increment/branch enable.
PcLoad  output  1  PC loads entry address of ProgIdx (PC logic holds that address while high).
ProgIdx  output  IDX_W  index of the program being armed or run.
Done  output  1  run finished; held until the next Start rise.
Timeout  output  1  last run ended by watchdog, not Halt; valid while Done=1.
CycleCount  output  CNT_W  RUN cycles of the current or last run.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset_n low asynchronously forces state IDLE and clears every output: CountEn=0, PcLoad=0, ProgIdx=0, Done=0, Timeout=0, CycleCount=0.
  - Release of Reset_n is synchronous to Clk. Start and Halt are synchronous inputs.
- Outputs: all registered (Moore, decoded from the state register). CountEn=1 only in RUN. PcLoad=1 only in ARMED. Done=1 only in DONE.
- States: IDLE, ARMED, RUN, DONE.
- IDLE:
  - Start=1 sampled → ARMED; ProgIdx stays 0.
  - Start=0 → stay in IDLE.
  - A Start already high when reset releases counts as a rise.
- ARMED:
  - PcLoad=1; CycleCount cleared to 0 on entry; Timeout cleared.
  - Start=0 sampled → RUN.
  - Latency: CountEn rises on the first edge after Start is sampled low.
- RUN:
  - CountEn=1; CycleCount += 1 each cycle in RUN.
  - Halt=1 → DONE. CountEn falls on that edge, so the PC stays on the halt instruction.
  - Else if CycleCount == MAX_CYCLES−1 → DONE with Timeout=1, and CycleCount = MAX_CYCLES.
  - Start=1 → ARMED (abort and restart the same ProgIdx). Start has priority over Halt and timeout in the same cycle.
  - Halt and timeout in the same cycle: Halt wins, Timeout=0.
- DONE:
  - Done=1; CountEn=0; CycleCount and Timeout frozen.
  - Start=1 → ARMED with ProgIdx ← (ProgIdx==PROG_COUNT−1) ? 0 : ProgIdx+1.
  - Halt is ignored in DONE.
- CycleCount never wraps: the watchdog terminates RUN before overflow.
- Reset mid-run (any state): immediate return to IDLE. The next run uses ProgIdx=0.
- Start glitches: Start held high in ARMED keeps the block in ARMED indefinitely with PcLoad=1. A Start pulse of one cycle is sufficient.

Test Plan:
- Reset then Start: Reset_n low 3 cycles, release; Start=1 for 2 cycles then 0; Halt=1 after 10 RUN cycles.
  -> PcLoad=1 while armed; CountEn=1 for exactly 10 cycles; Done=1, CycleCount=10, Timeout=0, ProgIdx=0.
- Sequential programs: repeat the Start pulse + Halt 4 times with PROG_COUNT=3.
  -> ProgIdx sequence 0,1,2,0; Done clears on each Start rise; CycleCount reset to 0 in ARMED each time.
- Watchdog: MAX_CYCLES=20, never assert Halt.
  -> DONE after 20 RUN cycles, Timeout=1, CycleCount=20, CountEn=0 from that edge on.
- Same-cycle events:
  - Halt=1 on the cycle CycleCount==MAX_CYCLES−1 -> Done=1, Timeout=0.
  - Start=1 and Halt=1 together in RUN -> ARMED, PcLoad=1, ProgIdx unchanged, Done=0.
- Async reset mid-run: drop Reset_n between clock edges while CountEn=1.
  -> all outputs 0 immediately, before the next Clk edge; after release plus a Start pulse, ProgIdx=0.
- Idle robustness: Halt toggling in IDLE and DONE with Start=0 for 50 cycles.
  -> no state change, CountEn stays 0, Done and CycleCount unchanged.
